dmem_dual_lane_sequencer: RTL and testbench

- Sits between the dual-issue memory stage and a single-port data memory or cache, replacing direct two-port access.
- Accepts one bundle of up to two load/store requests per cycle. Lane 0 is older in program order.
- Serialises the bundle onto one req/ready/rvalid memory port, strictly in program order, with at most one transaction outstanding.
- Holds the pipeline with `stall` until the bundle completes, then returns aligned, extended load data per lane.

---
 rtl/dmem_dual_lane_sequencer.sv | 148 ++++++++++++++
 tb/tb_dmem_dual_lane_sequencer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_dual_lane_sequencer.sv
// Serialises a two-lane load/store bundle onto a single req/ready/rvalid memory port.
// Lanes go out strictly in program order, one at a time. Load data is extracted, extended and registered per lane.
module dmem_dual_lane_sequencer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_valid,
   input  logic                flush,
   input  logic [1:0]          rd_en,
   input  logic [1:0]          wr_en,
   input  logic [5:0]          mem_type,
   input  logic [2*ADDR_W-1:0] addr,
   input  logic [2*DATA_W-1:0] wdata,
   output logic                stall,
   output logic                resp_valid,
   output logic [2*DATA_W-1:0] rdata,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [3:0]          mem_wstrb,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ready,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ0  = 3'd1;
   localparam logic [2:0] WAIT0 = 3'd2;
   localparam logic [2:0] REQ1  = 3'd3;
   localparam logic [2:0] WAIT1 = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;
   localparam logic [2:0] DRAIN = 3'd6;

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [1:0]        active;
   logic              lane;
   logic              issuing;
   logic              waiting;
   logic              lane_we;
   logic              lane_rd;
   logic [2:0]        lane_type;
   logic [ADDR_W-1:0] lane_addr;
   logic [DATA_W-1:0] lane_wdata;
   logic [3:0]        lane_wstrb;
   logic [DATA_W-1:0] lane_wrep;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] load_data;
   logic              capture;

   assign active     = rd_en | wr_en;
   assign lane       = (state == REQ1) || (state == WAIT1);
   assign issuing    = (state == REQ0) || (state == REQ1);
   assign waiting    = (state == WAIT0) || (state == WAIT1);
   assign lane_we    = wr_en[lane];
   assign lane_rd    = rd_en[lane];
   assign lane_type  = lane ? mem_type[5:3] : mem_type[2:0];
   assign lane_addr  = lane ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
   assign lane_wdata = lane ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];

   // Outputs depend only on the state register and the lane inputs held stable under stall.
   assign stall      = req_valid & (|active) & (state != DONE) & ~flush;
   assign resp_valid = (state == DONE);
   assign mem_req    = issuing;
   assign mem_we     = issuing & lane_we;
   assign mem_addr   = issuing ? {lane_addr[ADDR_W-1:2], 2'b00} : '0;
   assign mem_wstrb  = mem_we ? lane_wstrb : 4'b0000;
   assign mem_wdata  = mem_we ? lane_wrep : '0;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      lane_wstrb = 4'b1111;
      lane_wrep  = lane_wdata;
      case (lane_type)
         3'd0, 3'd1: begin
            lane_wstrb = 4'b0001 << lane_addr[1:0];
            lane_wrep  = {4{lane_wdata[7:0]}};
         end
         3'd2, 3'd3: begin
            lane_wstrb = lane_addr[1] ? 4'b1100 : 4'b0011;
            lane_wrep  = {2{lane_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (lane_addr[1:0])
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         2'd3:    byte_sel = mem_rdata[31:24];
         default: ;
      endcase
      half_sel  = lane_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_data = mem_rdata;
      case (lane_type)
         3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
         3'd1:    load_data = {24'd0, byte_sel};
         3'd2:    load_data = {{16{half_sel[15]}}, half_sel};
         3'd3:    load_data = {16'd0, half_sel};
         default: ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            if (req_valid && (|active) && !flush) state_nxt = active[0] ? REQ0 : REQ1;
         REQ0, REQ1:
            if (mem_ready)  state_nxt = flush ? DRAIN : ((state == REQ0) ? WAIT0 : WAIT1);
            else if (flush) state_nxt = IDLE;
         WAIT0, WAIT1:
            // A response arriving with the flush has already drained the port.
            if (mem_rvalid)      state_nxt = flush ? IDLE :
                                             ((state == WAIT0) && active[1]) ? REQ1 : DONE;
            else if (flush)      state_nxt = DRAIN;
         DONE:    state_nxt = IDLE;
         DRAIN:   if (mem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign capture = waiting & mem_rvalid & ~flush & lane_rd;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         rdata <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state <= state_nxt;
         if (capture) begin
            if (lane) rdata[2*DATA_W-1:DATA_W] <= load_data;
            else      rdata[DATA_W-1:0]        <= load_data;
         end
      end
   end

   rvalid_only_when_expected: assert property (@(posedge clk) disable iff (!resetn)
      mem_rvalid |-> (state == WAIT0 || state == WAIT1 || state == DRAIN));

endmodule

// File: tb/tb_dmem_dual_lane_sequencer.sv
// Self-checking bench: a byte-addressed memory responder plus a program-order reference model
// predicting transactions, stall length, resp_valid and the per-lane load results.
module tb_dmem_dual_lane_sequencer;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        flush = 1'b0;
   logic [1:0]  rd_en = '0;
   logic [1:0]  wr_en = '0;
   logic [5:0]  mem_type = '0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        stall;
   logic        resp_valid;
   logic [63:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   typedef struct {
      logic [31:0] a;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] d;
   } txn_t;

   txn_t        txn_log[$];
   logic [31:0] resp_mem [256];
   logic [31:0] ref_mem [256];
   logic [31:0] exp_rdata [2];
   int          ready_delay = 0;
   int          rvalid_delay = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   bit          rsp_pending = 1'b0;
   int          rsp_rv_left = 0;
   int          rsp_wait_left = -1;
   logic [31:0] rsp_word = '0;

   dmem_dual_lane_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .flush(flush),
      .rd_en(rd_en), .wr_en(wr_en), .mem_type(mem_type), .addr(addr), .wdata(wdata),
      .stall(stall), .resp_valid(resp_valid), .rdata(rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Memory responder: ready after ready_delay idle request cycles, response rvalid_delay cycles after accept.
   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            mem_ready = 1'b0;
            mem_rvalid = 1'b0;
            rsp_pending = 1'b0;
            rsp_wait_left = -1;
         end else begin
            #1;
            mem_rvalid = 1'b0;
            if (mem_ready) begin
               mem_ready = 1'b0;
               rsp_pending = 1'b1;
               rsp_rv_left = rvalid_delay;
            end
            if (rsp_pending) begin
               if (rsp_rv_left == 0) begin
                  mem_rvalid = 1'b1;
                  mem_rdata = rsp_word;
                  rsp_pending = 1'b0;
               end else begin
                  rsp_rv_left--;
               end
            end else if (mem_req) begin
               if (rsp_wait_left < 0) rsp_wait_left = ready_delay;
               if (rsp_wait_left == 0) begin
                  mem_ready = 1'b1;
                  rsp_wait_left = -1;
                  txn_log.push_back('{mem_addr, mem_we, mem_wstrb, mem_wdata});
                  if (mem_we) begin
                     for (int i = 0; i < 4; i++)
                        if (mem_wstrb[i]) resp_mem[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
                     rsp_word = '0;
                  end else begin
                     rsp_word = resp_mem[mem_addr[9:2]];
                  end
               end else begin
                  rsp_wait_left--;
               end
            end else begin
               rsp_wait_left = -1;
            end
         end
      end
   end

   function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] t,
                                            input logic [31:0] a);
      logic [31:0] b;
      logic [31:0] h;
      b = (word >> (8 * (a % 4))) & 32'hFF;
      h = (word >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      case (t)
         3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
         3'd1:    return b;
         3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'd3:    return h;
         default: return word;
      endcase
   endfunction

   task automatic preload(input logic [31:0] a, input logic [31:0] v);
      resp_mem[a[9:2]] = v;
      ref_mem[a[9:2]]  = v;
   endtask

   // Runs one bundle. flush_cyc < 0 means no flush; n_issue/n_complete bound how many active lanes
   // reach the memory / get their load result before the flush.
   task automatic run_bundle(input string name, input logic [1:0] r, input logic [1:0] w,
                             input logic [2:0] t0, input logic [2:0] t1,
                             input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input int flush_cyc, input int n_issue, input int n_complete);
      txn_t        full_q[$];
      logic [31:0] la [2];
      logic [31:0] ld [2];
      logic [2:0]  lt [2];
      logic [3:0]  strb;
      logic [31:0] data;
      logic [31:0] wa;
      int          k, n_act, n_iss, exp_stall, exp_resp, stall_cnt, resp_cnt, req_seen, sz, settle, qi;
      la[0] = a0; la[1] = a1; ld[0] = d0; ld[1] = d1; lt[0] = t0; lt[1] = t1;
      k = 0;
      exp_stall = 1;
      for (int l = 0; l < 2; l++) begin
         if (r[l] || w[l]) begin
            exp_stall += 2 + ready_delay + rvalid_delay;
            wa = la[l] & ~32'h3;
            if (w[l]) begin
               sz   = (lt[l] <= 3'd1) ? 1 : (lt[l] <= 3'd3) ? 2 : 4;
               strb = 4'(((1 << sz) - 1) << (la[l] % 4));
               data = (sz == 1) ? (ld[l] & 32'hFF) * 32'h01010101 :
                      (sz == 2) ? (ld[l] & 32'hFFFF) * 32'h00010001 : ld[l];
               full_q.push_back('{wa, 1'b1, strb, data});
               if (k < n_issue)
                  for (int i = 0; i < 4; i++)
                     if (strb[i]) ref_mem[wa[9:2]][8*i +: 8] = data[8*i +: 8];
            end else begin
               full_q.push_back('{wa, 1'b0, 4'b0000, 32'h0});
               if (k < n_complete) exp_rdata[l] = load_val(ref_mem[wa[9:2]], lt[l], la[l]);
            end
            k++;
         end
      end
      n_act     = k;
      n_iss     = (n_issue < n_act) ? n_issue : n_act;
      exp_stall = (flush_cyc >= 0) ? flush_cyc : ((n_act > 0) ? exp_stall : 0);
      exp_resp  = (flush_cyc < 0 && n_act > 0) ? 1 : 0;

      txn_log.delete();
      @(negedge clk);
      req_valid = 1'b1; rd_en = r; wr_en = w; mem_type = {t1, t0};
      addr = {a1, a0}; wdata = {d1, d0};
      stall_cnt = 0; resp_cnt = 0; req_seen = 0;
      for (int c = 0; c < 400; c++) begin
         flush = (c == flush_cyc);
         #1;
         if (mem_req && !mem_ready && txn_log.size() < full_q.size()) begin
            qi = txn_log.size();
            n_cmp++;
            if (mem_addr !== full_q[qi].a || mem_we !== full_q[qi].we) begin
               n_err++;
               $display("FAIL %s pending request cycle %0d: addr %h we %b, want addr %h we %b",
                        name, c, mem_addr, mem_we, full_q[qi].a, full_q[qi].we);
            end
         end
         if (resp_valid) begin
            resp_cnt++;
            break;
         end
         if (stall) stall_cnt++;
         else break;
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0; rd_en = '0; wr_en = '0;
      settle = (flush_cyc >= 0 || n_act == 0) ? 12 : 2;
      for (int s = 0; s < settle; s++) begin
         #1;
         if (resp_valid) resp_cnt++;
         if (mem_req) req_seen++;
         @(negedge clk);
      end

      n_cmp++;
      if (stall_cnt != exp_stall) begin
         n_err++;
         $display("FAIL %s stall cycles: got %0d want %0d", name, stall_cnt, exp_stall);
      end
      n_cmp++;
      if (resp_cnt != exp_resp) begin
         n_err++;
         $display("FAIL %s resp_valid cycles: got %0d want %0d", name, resp_cnt, exp_resp);
      end
      n_cmp++;
      if (req_seen != 0) begin
         n_err++;
         $display("FAIL %s mem_req after bundle: got %0d cycles want 0", name, req_seen);
      end
      n_cmp++;
      if (txn_log.size() != n_iss) begin
         n_err++;
         $display("FAIL %s transaction count: got %0d want %0d", name, txn_log.size(), n_iss);
      end else begin
         for (int i = 0; i < n_iss; i++) begin
            n_cmp++;
            if (txn_log[i].a !== full_q[i].a || txn_log[i].we !== full_q[i].we ||
                txn_log[i].strb !== full_q[i].strb ||
                (full_q[i].we && txn_log[i].d !== full_q[i].d)) begin
               n_err++;
               $display("FAIL %s txn %0d: got a=%h we=%b strb=%b d=%h want a=%h we=%b strb=%b d=%h",
                        name, i, txn_log[i].a, txn_log[i].we, txn_log[i].strb, txn_log[i].d,
                        full_q[i].a, full_q[i].we, full_q[i].strb, full_q[i].d);
            end
         end
      end
      n_cmp++;
      if (rdata !== {exp_rdata[1], exp_rdata[0]}) begin
         n_err++;
         $display("FAIL %s rdata: got %h want %h", name, rdata, {exp_rdata[1], exp_rdata[0]});
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #1;
      n_cmp++;
      if ({stall, resp_valid, mem_req, mem_we, mem_wstrb} !== 8'd0 || rdata !== 64'd0 ||
          mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
         n_err++;
         $display("FAIL reset outputs: stall=%b resp=%b req=%b we=%b strb=%b addr=%h wd=%h rdata=%h want all 0",
                  stall, resp_valid, mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata, rdata);
      end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      n_cmp++;
      if (stall !== 1'b0 || resp_valid !== 1'b0 || mem_req !== 1'b0) begin
         n_err++;
         $display("FAIL post-reset idle: stall=%b resp=%b req=%b want 0", stall, resp_valid, mem_req);
      end
   endtask

   task automatic test_single_lw();
      preload(32'h100, 32'hDEADBEEF);
      run_bundle("single_lw", 2'b01, 2'b00, 3'd4, 3'd0, 32'h100, 32'h0, 32'h0, 32'h0, -1, 9, 9);
      n_cmp++;
      if (rdata[31:0] !== 32'hDEADBEEF) begin
         n_err++;
         $display("FAIL single_lw rdata0: got %h want deadbeef", rdata[31:0]);
      end
   endtask

   task automatic test_dual_sb_lb();
      run_bundle("dual_sb_lb", 2'b10, 2'b01, 3'd0, 3'd0, 32'h203, 32'h203, 32'h80, 32'h0, -1, 9, 9);
      n_cmp++;
      if (txn_log.size() != 2 || txn_log[0].strb !== 4'b1000 || txn_log[0].d !== 32'h80808080 ||
          rdata[63:32] !== 32'hFFFFFF80) begin
         n_err++;
         $display("FAIL dual_sb_lb literal: got rdata1 %h (want ffffff80), txns %0d (want 2)",
                  rdata[63:32], txn_log.size());
      end
   endtask

   task automatic test_lhu_lh();
      preload(32'h100, 32'h9ABC1234);
      run_bundle("lhu", 2'b01, 2'b00, 3'd3, 3'd0, 32'h102, 32'h0, 32'h0, 32'h0, -1, 9, 9);
      n_cmp++;
      if (rdata[31:0] !== 32'h00009ABC) begin
         n_err++;
         $display("FAIL lhu literal: got %h want 00009abc", rdata[31:0]);
      end
      run_bundle("lh", 2'b01, 2'b00, 3'd2, 3'd0, 32'h102, 32'h0, 32'h0, 32'h0, -1, 9, 9);
      n_cmp++;
      if (rdata[31:0] !== 32'hFFFF9ABC) begin
         n_err++;
         $display("FAIL lh literal: got %h want ffff9abc", rdata[31:0]);
      end
   endtask

   task automatic test_backpressure();
      ready_delay = 4;
      run_bundle("backpressure", 2'b01, 2'b00, 3'd4, 3'd0, 32'h104, 32'h0, 32'h0, 32'h0, -1, 9, 9);
      ready_delay = 0;
   endtask

   task automatic test_flush_wait1();
      rvalid_delay = 2;
      // WAIT1 starts at cycle 4 + 2*ready_delay + rvalid_delay = 6.
      run_bundle("flush_wait1", 2'b10, 2'b01, 3'd4, 3'd4, 32'h140, 32'h144, 32'h11223344, 32'h0, 6, 2, 1);
      rvalid_delay = 0;
      run_bundle("after_flush", 2'b01, 2'b00, 3'd4, 3'd0, 32'h140, 32'h0, 32'h0, 32'h0, -1, 9, 9);
   endtask

   task automatic test_flush_req();
      ready_delay = 3;
      run_bundle("flush_req0", 2'b00, 2'b01, 3'd4, 3'd0, 32'h148, 32'h0, 32'h55AA55AA, 32'h0, 2, 0, 0);
      ready_delay = 0;
      run_bundle("no_side_effect", 2'b01, 2'b00, 3'd4, 3'd0, 32'h148, 32'h0, 32'h0, 32'h0, -1, 9, 9);
   endtask

   task automatic test_lane1_only();
      run_bundle("lane1_sh", 2'b00, 2'b10, 3'd0, 3'd2, 32'h0, 32'h152, 32'h0, 32'hCAFE, -1, 9, 9);
      run_bundle("lane1_lhu", 2'b10, 2'b00, 3'd0, 3'd3, 32'h0, 32'h152, 32'h0, 32'h0, -1, 9, 9);
   endtask

   task automatic test_idle_bundle();
      run_bundle("no_active", 2'b00, 2'b00, 3'd4, 3'd4, 32'h100, 32'h104, 32'h1, 32'h2, -1, 9, 9);
   endtask

   task automatic test_random();
      logic [1:0]  r, w;
      logic [2:0]  t [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      int          op, sz;
      for (int n = 0; n < 40; n++) begin
         for (int l = 0; l < 2; l++) begin
            op   = int'($urandom_range(0, 2));
            r[l] = (op == 1);
            w[l] = (op == 2);
            t[l] = 3'($urandom_range(0, 7));
            sz   = (t[l] <= 3'd1) ? 1 : (t[l] <= 3'd3) ? 2 : 4;
            a[l] = 32'h100 + 32'd4 * $urandom_range(0, 15) + 32'(sz) * $urandom_range(0, 4 / sz - 1);
            d[l] = $urandom;
         end
         if ($urandom_range(0, 2) == 0) a[1] = (a[0] & ~32'h3) | (a[1] & 32'h3);
         ready_delay  = int'($urandom_range(0, 2));
         rvalid_delay = int'($urandom_range(0, 2));
         run_bundle($sformatf("rand%0d", n), r, w, t[0], t[1], a[0], a[1], d[0], d[1], -1, 9, 9);
      end
      ready_delay = 0;
      rvalid_delay = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req_valid = 1'b1; rd_en = 2'b01; wr_en = 2'b00; mem_type = 6'o04; addr = {32'h0, 32'h108};
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      req_valid = 1'b0; rd_en = '0;
      #1;
      n_cmp++;
      if (mem_req !== 1'b0 || resp_valid !== 1'b0 || rdata !== 64'd0) begin
         n_err++;
         $display("FAIL reset_mid: req=%b resp=%b rdata=%h want 0/0/0", mem_req, resp_valid, rdata);
      end
      @(negedge clk);
      resetn = 1'b1;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      run_bundle("after_reset", 2'b11, 2'b00, 3'd4, 3'd1, 32'h100, 32'h101, 32'h0, 32'h0, -1, 9, 9);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         resp_mem[i] = '0;
         ref_mem[i]  = '0;
      end
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      test_reset();
      test_single_lw();
      test_dual_sb_lb();
      test_lhu_lh();
      test_backpressure();
      test_flush_wait1();
      test_flush_req();
      test_lane1_only();
      test_idle_bundle();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
